// File: rtl/cpu_idle_dma_sched.sv
// cpu_idle_dma_sched
// Slots PI-side DMA accesses to the shared PRG ROM / SRM bus into the
// CPU-idle part of each M2 cycle (M2 low). When M2 stops toggling for
// IDLE_TMO clocks (console halted or off), accesses run without waiting
// for an M2 fall.
// Optional build macro: DMA_STAT_EN adds the ovr_cnt/acc_cnt statistics ports.
// SETUP_CYC and ACC_CYC must each be in 1..16 (4-bit phase counter).

module cpu_idle_dma_sched #(
  parameter int SETUP_CYC = 2,
  parameter int ACC_CYC   = 4,
  parameter int IDLE_TMO  = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m2,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_srm,
  input  logic [22:0] dma_addr,
  input  logic [7:0]  dma_di,
  input  logic [7:0]  mem_do,
  output logic        dma_ack,
  output logic [7:0]  dma_do,
  output logic        sel_prg,
  output logic        sel_srm,
  output logic        mem_ce,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_dati,
  output logic        busy
`ifdef DMA_STAT_EN
  ,
  output logic [7:0]  ovr_cnt,
  output logic [15:0] acc_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_ACCESS,
    S_RELEASE
  } state_t;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0] ACC_LAST   = 4'(ACC_CYC - 1);
  localparam logic [7:0] TMO_MAX    = 8'(IDLE_TMO);

  state_t      state, state_nx;
  logic [3:0]  phase_cnt, phase_nx;
  logic        m2_meta, m2_sync, m2_prev;
  logic        m2_fall, m2_rise, m2_edge;
  logic [7:0]  tmo_cnt;
  logic        freerun;
  logic        latch_en;
  logic        capture_en;
  logic        acc_we;
  logic        acc_srm;
  logic        sel_on;

  // Two-flop synchroniser for the asynchronous M2, plus one history flop for edge detection.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values; = here would collapse the synchroniser chain into one flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m2_meta <= 1'b0;
      m2_sync <= 1'b0;
      m2_prev <= 1'b0;
    end else begin
      m2_meta <= m2;
      m2_sync <= m2_meta;
      m2_prev <= m2_sync;
    end
  end

  assign m2_fall = m2_prev & ~m2_sync;
  assign m2_rise = ~m2_prev & m2_sync;
  assign m2_edge = m2_prev ^ m2_sync;

  // Idle timeout: cycles since the last M2 edge, saturating at IDLE_TMO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= 8'd0;
    end else if (m2_edge) begin
      tmo_cnt <= 8'd0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // Free-run holds exactly while the counter sits at its saturation value.
  assign freerun = (tmo_cnt == TMO_MAX);

  // State register and SETUP/ACCESS phase counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      phase_cnt <= 4'd0;
    end else begin
      state     <= state_nx;
      phase_cnt <= phase_nx;
    end
  end

  // Next-state logic and bus outputs decoded from the current state.
  // NOTE: every signal gets its default first so no path through the case leaves one unassigned (which would infer a latch).
  always_comb begin
    state_nx   = state;
    phase_nx   = phase_cnt;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (dma_req) begin
          latch_en = 1'b1;
          phase_nx = 4'd0;
          state_nx = (m2_fall || freerun) ? S_SETUP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (m2_fall || freerun) begin
          phase_nx = 4'd0;
          state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        // CPU came back before the access started: back off, keep the request.
        if (m2_sync && !freerun) begin
          state_nx = S_WAIT;
        end else if (phase_cnt == SETUP_LAST) begin
          phase_nx = 4'd0;
          state_nx = S_ACCESS;
        end else begin
          phase_nx = phase_cnt + 4'd1;
        end
      end
      S_ACCESS: begin
        // Once the strobes are up the access always completes.
        if (phase_cnt == ACC_LAST) begin
          capture_en = ~acc_we;
          state_nx   = S_RELEASE;
        end else begin
          phase_nx = phase_cnt + 4'd1;
        end
      end
      S_RELEASE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase

    sel_on  = (state == S_SETUP) || (state == S_ACCESS) || (state == S_RELEASE);
    sel_prg = sel_on & ~acc_srm;
    sel_srm = sel_on & acc_srm;
    mem_ce  = (state == S_ACCESS);
    mem_oe  = (state == S_ACCESS) & ~acc_we;
    mem_we  = (state == S_ACCESS) & acc_we;
    dma_ack = (state == S_RELEASE);
    busy    = (state != S_IDLE);
  end

  // Request latch and read-data capture.
  // NOTE: these are a handful of flops, not a memory array, so they are all reset to give clean zero outputs after rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_we   <= 1'b0;
      acc_srm  <= 1'b0;
      mem_addr <= 23'd0;
      mem_dati <= 8'd0;
      dma_do   <= 8'd0;
    end else begin
      if (latch_en) begin
        acc_we   <= dma_we;
        acc_srm  <= dma_srm;
        mem_addr <= dma_addr;
        mem_dati <= dma_di;
      end
      if (capture_en) begin
        dma_do <= mem_do;
      end
    end
  end

`ifdef DMA_STAT_EN
  // Statistics: M2 rises during ACCESS (overruns, saturating) and completed accesses (wrapping).
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovr_cnt <= 8'd0;
      acc_cnt <= 16'd0;
    end else begin
      if ((state == S_ACCESS) && m2_rise && (ovr_cnt != 8'hFF)) begin
        ovr_cnt <= ovr_cnt + 8'd1;
      end
      if (state == S_RELEASE) begin
        acc_cnt <= acc_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_idle_dma_sched.sv
// tb_cpu_idle_dma_sched
// Drives a pre-generated M2 waveform (normal windows, one short low phase,
// one overrun-length low phase, one 200-cycle halt) with random DMA traffic,
// and compares the DUT cycle by cycle against a timeline predicted from the
// waveform. Ends with a reset in the middle of an access.
// Build with DMA_STAT_EN defined to also check the statistics counters.

module tb_cpu_idle_dma_sched;

  localparam int SETUP_CYC = 2;
  localparam int ACC_CYC   = 4;
  localparam int IDLE_TMO  = 127;
  localparam int N         = 3200;
  localparam int SHORT_SEG = 55;
  localparam int OVR_SEG   = 58;
  localparam int HALT_SEG  = 62;

  logic        clk = 1'b0;
  logic        rst, m2, dma_req, dma_we, dma_srm;
  logic [22:0] dma_addr;
  logic [7:0]  dma_di, mem_do;
  logic        dma_ack, sel_prg, sel_srm, mem_ce, mem_oe, mem_we, busy;
  logic [7:0]  dma_do, mem_dati;
  logic [22:0] mem_addr;
`ifdef DMA_STAT_EN
  logic [7:0]  ovr_cnt;
  logic [15:0] acc_cnt;
`endif

  always #10 clk = ~clk;

  cpu_idle_dma_sched dut (
    .clk(clk), .rst(rst), .m2(m2),
    .dma_req(dma_req), .dma_we(dma_we), .dma_srm(dma_srm),
    .dma_addr(dma_addr), .dma_di(dma_di), .mem_do(mem_do),
    .dma_ack(dma_ack), .dma_do(dma_do),
    .sel_prg(sel_prg), .sel_srm(sel_srm),
    .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_dati(mem_dati), .busy(busy)
`ifdef DMA_STAT_EN
    , .ovr_cnt(ovr_cnt), .acc_cnt(acc_cnt)
`endif
  );

  // Waveform and predicted timeline, indexed by cycle (number of clk rises so far).
  bit       raw      [0:N-1];
  bit       fr_arr   [0:N-1];
  bit       exp_sel  [0:N-1];
  bit       exp_ce   [0:N-1];
  bit       exp_ack  [0:N-1];
  bit       exp_busy [0:N-1];
  logic [7:0] mdo    [0:N-1];
  int       seg_start [0:399];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // M2 as seen by the DUT: two synchroniser stages behind the driven value.
  function automatic bit raw_at(int t);
    return (t < 0 || t >= N) ? 1'b0 : raw[t];
  endfunction
  function automatic bit sync_at(int t);
    return raw_at(t - 2);
  endfunction
  function automatic bit prev_at(int t);
    return raw_at(t - 3);
  endfunction
  function automatic bit fall_at(int t);
    return prev_at(t) && !sync_at(t);
  endfunction

  // Timeline of one request first seen in IDLE at cycle r: find the idle window
  // start, try the setup phase, retry after a back-off, then access and ack.
  task automatic predict(input int r, output int ack);
    int t;
    int ab;
    t   = r;
    ack = -1;
    while (t < N - 16 && ack < 0) begin
      if (fall_at(t) || fr_arr[t]) begin
        ab = -1;
        for (int s = t + 1; s <= t + SETUP_CYC; s++) begin
          if (ab < 0) begin
            exp_sel[s] = 1'b1;
            if (sync_at(s) && !fr_arr[s]) ab = s;
          end
        end
        if (ab >= 0) begin
          t = ab + 1;
        end else begin
          for (int s = t + SETUP_CYC + 1; s <= t + SETUP_CYC + ACC_CYC; s++) begin
            exp_sel[s] = 1'b1;
            exp_ce[s]  = 1'b1;
          end
          ack = t + SETUP_CYC + ACC_CYC + 1;
          exp_sel[ack] = 1'b1;
          exp_ack[ack] = 1'b1;
        end
      end else begin
        t++;
      end
    end
    if (ack > 0) begin
      for (int s = r + 1; s <= ack; s++) exp_busy[s] = 1'b1;
    end
  endtask

  initial begin
    int t, seg, hi, lo, last, b_start, b_end;
    int pend, pred_ack, req_cyc, next_req, n_txn, drop_early, in_b, found, acks_seen;
    int n_ack_model, ovr_model;
    logic        t_we, t_srm;
    logic [22:0] t_addr;
    logic [7:0]  t_di, model_do;

    // Build the M2 waveform: low through reset, then high/low segments.
    t = 0;
    while (t < 12) begin raw[t] = 1'b0; t++; end
    seg = 0;
    while (t < N && seg < 400) begin
      seg_start[seg] = t;
      hi = (seg == HALT_SEG) ? 200 : $urandom_range(10, 16);
      lo = (seg == SHORT_SEG) ? 2 : (seg == OVR_SEG) ? 4 : $urandom_range(10, 16);
      for (int i = 0; i < hi && t < N; i++) begin raw[t] = 1'b1; t++; end
      for (int i = 0; i < lo && t < N; i++) begin raw[t] = 1'b0; t++; end
      seg++;
    end
    for (int i = 0; i < N; i++) mdo[i] = 8'($urandom);

    // Free-run: IDLE_TMO or more cycles since the counter last restarted.
    last = 4;
    for (int i = 0; i < N; i++) begin
      fr_arr[i] = (i >= 4) && ((i - last) >= IDLE_TMO);
      if (i >= 4 && (sync_at(i) != prev_at(i))) last = i + 1;
    end
    b_start = seg_start[50];
    b_end   = seg_start[75];

    rst = 1'b0; m2 = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_srm = 1'b0;
    dma_addr = 23'd0; dma_di = 8'd0; mem_do = 8'd0;
    pend = 0; pred_ack = -1; req_cyc = 0; next_req = 20; n_txn = 0; drop_early = 0;
    t_we = 1'b0; t_srm = 1'b0; t_addr = 23'd0; t_di = 8'd0; model_do = 8'd0;

    for (int k = 1; k < N; k++) begin
      @(posedge clk);
      cyc = k;
      #1;
      rst    = (cyc >= 4);
      m2     = raw[cyc];
      mem_do = mdo[cyc];
      in_b   = (cyc >= b_start && cyc < b_end);

      if (pend != 0 && cyc == pred_ack + 1) begin
        pend    = 0;
        dma_req = 1'b0;
        if (in_b) begin
          next_req = cyc;
        end else if (n_txn == 1) begin
          next_req = cyc + 1;
          while (next_req < N - 1 && !raw[next_req]) next_req++;
          next_req++;
        end else begin
          next_req = cyc + $urandom_range(1, 40);
        end
      end

      if (pend == 0 && cyc >= next_req && cyc < N - 200) begin
        if (n_txn == 0) begin
          t_we = 1'b0; t_srm = 1'b0; t_addr = 23'h001234; t_di = 8'h00;
        end else if (n_txn == 1) begin
          t_we = 1'b1; t_srm = 1'b1; t_addr = 23'h000010; t_di = 8'h3C;
        end else begin
          t_we = 1'($urandom_range(0, 1)); t_srm = 1'($urandom_range(0, 1));
          t_addr = 23'($urandom); t_di = 8'($urandom);
        end
        dma_req = 1'b1; dma_we = t_we; dma_srm = t_srm; dma_addr = t_addr; dma_di = t_di;
        req_cyc = cyc;
        predict(cyc, pred_ack);
        check("predict_found", 32'(pred_ack > cyc), 32'd1);
        if (pred_ack < 0) pred_ack = N + 10;
        if (n_txn == 0 && pred_ack < N) mdo[pred_ack - 1] = 8'hA5;
        drop_early = (!in_b && n_txn > 1 && $urandom_range(0, 3) == 0);
        pend = 1;
        n_txn++;
      end else if (pend != 0 && drop_early != 0 && cyc == req_cyc + 1) begin
        dma_req = 1'b0;
      end

      @(negedge clk);
      if (exp_ack[cyc] && !t_we) model_do = mdo[cyc - 1];
      check("sel_prg", sel_prg, exp_sel[cyc] && !t_srm);
      check("sel_srm", sel_srm, exp_sel[cyc] && t_srm);
      check("mem_ce", mem_ce, exp_ce[cyc]);
      check("mem_oe", mem_oe, exp_ce[cyc] && !t_we);
      check("mem_we", mem_we, exp_ce[cyc] && t_we);
      check("dma_ack", dma_ack, exp_ack[cyc]);
      check("busy", busy, exp_busy[cyc]);
      check("dma_do", dma_do, model_do);
      if (exp_sel[cyc]) begin
        check("mem_addr", mem_addr, t_addr);
        check("mem_dati", mem_dati, t_di);
      end
      if (cyc == 4) begin
        check("reset_addr", mem_addr, 23'd0);
        check("reset_dati", mem_dati, 8'd0);
      end
    end

`ifdef DMA_STAT_EN
    n_ack_model = 0;
    ovr_model   = 0;
    for (int i = 0; i < N; i++) begin
      if (exp_ack[i]) n_ack_model++;
      if (exp_ce[i] && !prev_at(i) && sync_at(i) && ovr_model < 255) ovr_model++;
    end
    check("acc_cnt", acc_cnt, n_ack_model % 65536);
    check("ovr_cnt", ovr_cnt, ovr_model);
`endif

    // Reset during the second access cycle of a read.
    m2 = 1'b1; dma_req = 1'b0;
    repeat (8) begin @(posedge clk); cyc++; #1; end
    dma_req = 1'b1; dma_we = 1'b0; dma_srm = 1'b0; dma_addr = 23'h0055AA; m2 = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(posedge clk); cyc++; #1;
      @(negedge clk);
      if (mem_ce === 1'b1) found = 1;
    end
    check("rst_access_seen", found, 1);
    @(posedge clk); cyc++; #1;
    rst = 1'b0;
    @(posedge clk); cyc++; #1;
    rst = 1'b1; dma_req = 1'b0;
    @(negedge clk);
    check("rst_sel_prg", sel_prg, 1'b0);
    check("rst_sel_srm", sel_srm, 1'b0);
    check("rst_mem_ce", mem_ce, 1'b0);
    check("rst_mem_oe", mem_oe, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_dma_ack", dma_ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dma_do", dma_do, 8'd0);
    check("rst_mem_addr", mem_addr, 23'd0);
    check("rst_mem_dati", mem_dati, 8'd0);
`ifdef DMA_STAT_EN
    check("rst_ovr_cnt", ovr_cnt, 8'd0);
    check("rst_acc_cnt", acc_cnt, 16'd0);
`endif
    acks_seen = 0;
    repeat (12) begin
      @(posedge clk); cyc++; #1;
      @(negedge clk);
      if (dma_ack !== 1'b0) acks_seen++;
    end
    check("rst_no_ack", acks_seen, 0);
    check("rst_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
